decode_mux: RTL and testbench
=============================

// Module: decode_mux
// PURPOSE
//  Final decode stage: merges the A, B and D format-specific decoders into one registered uop stream for issue.
//  Selects one valid format per cycle and copies its common fields and rw/isReg flags to the outputs.
//  Packs that format's operand body into a 64-bit body_o.
// PARAMETERS
//  addressWidth 64 : instruction address width
//  opcodeSize 12 : internal opcode width
//  regSize 5 : register specifier width
//  PidSize 20 / TidSize 16 : process / thread id widths
//  instructionCounterWidth 64 : major id width
//  instMinIdWidth 5 : minor id / micro-op count width
//  funcUnitCodeSize 3 : functional unit code (FX0 FP1 VX2 CR3 LS4 BR6)
//  regAccessPatternSize 2 : rw code; 2'b10 = read, 2'b01 = write, 2'b11 = both, 2'b00 = unused
//  BimmediateSize 14, DimmediateSize 16 : immediate widths
// PORTS (bit 0 = MSB on all vectors)
//  clock_i  in  1  clock; rising edge
//  reset_i  in  1  asynchronous active-low reset
//  Per format X in {A,B,D}:
//   Xenable_i  in  1  valid
//   XOpcode_i  in  12  opcode
//   XAddress_i  in  64  address
//   XUnitType_i  in  3  unit
//   XMajId_i  in  64  major id
//   XMinId_i, XnumMicroOps_i  in  5 each  minor id / uop count
//   Xis64Bit_i  in  1  64-bit mode
//   XPid_i  in  20  process id
//   XTid_i  in  16  thread id
//  Aop1rw_i..Aop4rw_i  in  2 each;  Aop1IsReg_i..Aop4IsReg_i  in  1 each
//  ABody_i  in  21  4 x 5-bit operands + Rc bit
//  BBody_i  in  28  BO, BI, BD(14), AA, LK, 2 spare
//  Dop1rw_i, Dop2rw_i  in  2;  Dop1isReg_i, Dop2isReg_i  in  1
//  immIsExtended_i  in  1  sign-extend the immediate
//  immIsShifted_i  in  1  shift the immediate
//  DisShiftedBy_i  in  3  shift count in bytes
//  DBody_i  in  26  RT(5), RA(5), imm(16)
//  enable_o  out  1  output uop valid
//  opcode_o, address_o, funcUnitType_o, majID_o, minID_o, numMicroOps_o, is64Bit_o, pid_o, tid_o
//   out  widths as inputs; selected format's fields
//  op1rw_o..op4rw_o  out  2;  op1IsReg_o..op4IsReg_o  out  1
//  modifiesCR_o  out  1  uop writes CR
//  body_o  out  64  packed operands
// BEHAVIOUR
//  - Reset low (async): every output is 0, enable_o is 0.
//  - All outputs are registered on the rising clock_i; latency is 1 cycle; no backpressure.
//  - Priority when several enables are high: A > B > D; lower-priority inputs are dropped.
//  - No enable high: enable_o <= 0; all other outputs hold their previous value.
//  - A selected:
//   - opN rw/isReg = Aop*_i.
//   - body_o[0:20] = ABody_i; body_o[21:63] = 0.
//   - modifiesCR_o = ABody_i[20].
//  - B selected:
//   - all opN rw = 00, all isReg = 0.
//   - body_o[0:27] = BBody_i; rest = 0.
//   - modifiesCR_o = 0.
//  - D selected:
//   - op1/op2 rw/isReg = D inputs; op3/op4 = 0.
//   - body_o[0:4] = RT; body_o[5:9] = RA.
//   - body_o[10:63] = imm16 extended to 54 bits: sign-extended if immIsExtended_i, else zero-extended.
//   - If immIsShifted_i, that value is then shifted left by 8*DisShiftedBy_i within the 54 bits; overflow is discarded.
//   - modifiesCR_o = 0.
//  - Reset asserted mid-stream clears outputs immediately; the first enable after release is captured normally.
// TESTING
//  1. Reset low -> all outputs 0. Release with no enables, clock -> enable_o stays 0.
//  2. A stimulus: Opcode 4, Unit 1, is64 1, rw 01/10/00/10, isReg 1/1/0/1, ABody_i 21'b10001_01110_11111_00000_1, one clock
//     -> enable_o 1, opcode_o 4, funcUnitType_o 1, op rw/isReg as driven, body_o[0:20] = ABody_i, body_o[21:63] = 0, modifiesCR_o 1.
//     Drop enable, clock -> enable_o 0, other fields held.
//  3. D stimulus: DBody_i RT=3, RA=1, imm=16'hFFFE, extended=1, shifted=0
//     -> body_o[10:63] = 54'h3FFFFFFFFFFFFE, op3/op4 rw = 00.
//     Repeat with imm=1, shifted=1, by=2 -> body_o[10:63] = 54'h10000.
//  4. A and D enabled in the same cycle -> A fields output and the D uop is dropped.
//     B and D enabled together -> B fields output, modifiesCR_o 0.
//  5. Reset asserted between clocks while enable_o = 1 -> outputs 0 at once, with no clock edge needed.

Source files
------------

// File: rtl/decode_mux.sv
// decode_mux: final decode stage. Merges the A, B and D format decoders into one registered
// uop stream (A > B > D priority, 1-cycle latency, no backpressure).
// Vectors are declared [W-1:0]. Field positions follow MSB-first numbering, so "field bit 0" is
// the top bit of the vector. For example, ABody occupies body_o[63:43] and its Rc bit is ABody_i[0].
module decode_mux #(
  parameter int unsigned addressWidth            = 64,
  parameter int unsigned opcodeSize              = 12,
  parameter int unsigned regSize                 = 5,
  parameter int unsigned PidSize                 = 20,
  parameter int unsigned TidSize                 = 16,
  parameter int unsigned instructionCounterWidth = 64,
  parameter int unsigned instMinIdWidth          = 5,
  parameter int unsigned funcUnitCodeSize        = 3,
  parameter int unsigned regAccessPatternSize    = 2,
  parameter int unsigned BimmediateSize          = 14,
  parameter int unsigned DimmediateSize          = 16
) (
  input  logic                               clock_i,
  input  logic                               reset_i,
  // A format
  input  logic                               Aenable_i,
  input  logic [opcodeSize-1:0]              AOpcode_i,
  input  logic [addressWidth-1:0]            AAddress_i,
  input  logic [funcUnitCodeSize-1:0]        AUnitType_i,
  input  logic [instructionCounterWidth-1:0] AMajId_i,
  input  logic [instMinIdWidth-1:0]          AMinId_i,
  input  logic [instMinIdWidth-1:0]          AnumMicroOps_i,
  input  logic                               Ais64Bit_i,
  input  logic [PidSize-1:0]                 APid_i,
  input  logic [TidSize-1:0]                 ATid_i,
  input  logic [regAccessPatternSize-1:0]    Aop1rw_i,
  input  logic [regAccessPatternSize-1:0]    Aop2rw_i,
  input  logic [regAccessPatternSize-1:0]    Aop3rw_i,
  input  logic [regAccessPatternSize-1:0]    Aop4rw_i,
  input  logic                               Aop1IsReg_i,
  input  logic                               Aop2IsReg_i,
  input  logic                               Aop3IsReg_i,
  input  logic                               Aop4IsReg_i,
  input  logic [4*regSize:0]                 ABody_i,
  // B format
  input  logic                               Benable_i,
  input  logic [opcodeSize-1:0]              BOpcode_i,
  input  logic [addressWidth-1:0]            BAddress_i,
  input  logic [funcUnitCodeSize-1:0]        BUnitType_i,
  input  logic [instructionCounterWidth-1:0] BMajId_i,
  input  logic [instMinIdWidth-1:0]          BMinId_i,
  input  logic [instMinIdWidth-1:0]          BnumMicroOps_i,
  input  logic                               Bis64Bit_i,
  input  logic [PidSize-1:0]                 BPid_i,
  input  logic [TidSize-1:0]                 BTid_i,
  input  logic [2*regSize+BimmediateSize+3:0] BBody_i,
  // D format
  input  logic                               Denable_i,
  input  logic [opcodeSize-1:0]              DOpcode_i,
  input  logic [addressWidth-1:0]            DAddress_i,
  input  logic [funcUnitCodeSize-1:0]        DUnitType_i,
  input  logic [instructionCounterWidth-1:0] DMajId_i,
  input  logic [instMinIdWidth-1:0]          DMinId_i,
  input  logic [instMinIdWidth-1:0]          DnumMicroOps_i,
  input  logic                               Dis64Bit_i,
  input  logic [PidSize-1:0]                 DPid_i,
  input  logic [TidSize-1:0]                 DTid_i,
  input  logic [regAccessPatternSize-1:0]    Dop1rw_i,
  input  logic [regAccessPatternSize-1:0]    Dop2rw_i,
  input  logic                               Dop1isReg_i,
  input  logic                               Dop2isReg_i,
  input  logic                               immIsExtended_i,
  input  logic                               immIsShifted_i,
  input  logic [2:0]                         DisShiftedBy_i,
  input  logic [2*regSize+DimmediateSize-1:0] DBody_i,
  // Merged uop
  output logic                               enable_o,
  output logic [opcodeSize-1:0]              opcode_o,
  output logic [addressWidth-1:0]            address_o,
  output logic [funcUnitCodeSize-1:0]        funcUnitType_o,
  output logic [instructionCounterWidth-1:0] majID_o,
  output logic [instMinIdWidth-1:0]          minID_o,
  output logic [instMinIdWidth-1:0]          numMicroOps_o,
  output logic                               is64Bit_o,
  output logic [PidSize-1:0]                 pid_o,
  output logic [TidSize-1:0]                 tid_o,
  output logic [regAccessPatternSize-1:0]    op1rw_o,
  output logic [regAccessPatternSize-1:0]    op2rw_o,
  output logic [regAccessPatternSize-1:0]    op3rw_o,
  output logic [regAccessPatternSize-1:0]    op4rw_o,
  output logic                               op1IsReg_o,
  output logic                               op2IsReg_o,
  output logic                               op3IsReg_o,
  output logic                               op4IsReg_o,
  output logic                               modifiesCR_o,
  output logic [63:0]                        body_o
);

  localparam int unsigned BodyWidth   = 64;
  localparam int unsigned ABodyWidth  = 4 * regSize + 1;
  localparam int unsigned BBodyWidth  = 2 * regSize + BimmediateSize + 4;
  localparam int unsigned DRegsWidth  = 2 * regSize;
  localparam int unsigned DImmExtSize = BodyWidth - DRegsWidth;

  typedef struct packed {
    logic [opcodeSize-1:0]              opcode;
    logic [addressWidth-1:0]            address;
    logic [funcUnitCodeSize-1:0]        unitType;
    logic [instructionCounterWidth-1:0] majId;
    logic [instMinIdWidth-1:0]          minId;
    logic [instMinIdWidth-1:0]          numMicroOps;
    logic                               is64Bit;
    logic [PidSize-1:0]                 pid;
    logic [TidSize-1:0]                 tid;
  } commonT;

  typedef struct packed {
    logic [regAccessPatternSize-1:0] op1rw;
    logic [regAccessPatternSize-1:0] op2rw;
    logic [regAccessPatternSize-1:0] op3rw;
    logic [regAccessPatternSize-1:0] op4rw;
    logic                            op1IsReg;
    logic                            op2IsReg;
    logic                            op3IsReg;
    logic                            op4IsReg;
  } opFlagsT;

  commonT  aCommon, bCommon, dCommon;
  commonT  commonD, commonQ;
  opFlagsT flagsD, flagsQ;
  logic    enableD, enableQ;
  logic    crD, crQ;
  logic [BodyWidth-1:0] bodyD, bodyQ;

  logic [DimmediateSize-1:0] dImm;
  logic [DImmExtSize-1:0]    dImmExt;
  logic [DImmExtSize-1:0]    dImmShifted;

  assign aCommon = {AOpcode_i, AAddress_i, AUnitType_i, AMajId_i, AMinId_i, AnumMicroOps_i,
                    Ais64Bit_i, APid_i, ATid_i};
  assign bCommon = {BOpcode_i, BAddress_i, BUnitType_i, BMajId_i, BMinId_i, BnumMicroOps_i,
                    Bis64Bit_i, BPid_i, BTid_i};
  assign dCommon = {DOpcode_i, DAddress_i, DUnitType_i, DMajId_i, DMinId_i, DnumMicroOps_i,
                    Dis64Bit_i, DPid_i, DTid_i};

  // D immediate: extend to fill the body below RT/RA, then optionally shift by whole bytes.
  // Shift counts past the field width simply leave zero.
  always_comb begin
    dImm = DBody_i[DimmediateSize-1:0];
    if (immIsExtended_i) begin
      dImmExt = {{(DImmExtSize - DimmediateSize){dImm[DimmediateSize-1]}}, dImm};
    end else begin
      dImmExt = {{(DImmExtSize - DimmediateSize){1'b0}}, dImm};
    end
    if (immIsShifted_i) begin
      dImmShifted = dImmExt << {DisShiftedBy_i, 3'b000};
    end else begin
      dImmShifted = dImmExt;
    end
  end

  // Select the highest-priority valid format; hold every field when nothing is valid.
  always_comb begin
    enableD = 1'b0;
    commonD = commonQ;
    flagsD  = flagsQ;
    crD     = crQ;
    bodyD   = bodyQ;
    if (Aenable_i) begin
      enableD = 1'b1;
      commonD = aCommon;
      flagsD  = {Aop1rw_i, Aop2rw_i, Aop3rw_i, Aop4rw_i,
                 Aop1IsReg_i, Aop2IsReg_i, Aop3IsReg_i, Aop4IsReg_i};
      crD     = ABody_i[0];
      bodyD   = {ABody_i, {(BodyWidth - ABodyWidth){1'b0}}};
    end else if (Benable_i) begin
      enableD = 1'b1;
      commonD = bCommon;
      flagsD  = '0;
      crD     = 1'b0;
      bodyD   = {BBody_i, {(BodyWidth - BBodyWidth){1'b0}}};
    end else if (Denable_i) begin
      enableD = 1'b1;
      commonD = dCommon;
      flagsD  = '0;
      flagsD.op1rw    = Dop1rw_i;
      flagsD.op2rw    = Dop2rw_i;
      flagsD.op1IsReg = Dop1isReg_i;
      flagsD.op2IsReg = Dop2isReg_i;
      crD     = 1'b0;
      bodyD   = {DBody_i[DRegsWidth+DimmediateSize-1:DimmediateSize], dImmShifted};
    end
  end

  // Output registers; asynchronous reset clears the whole uop.
  always_ff @(posedge clock_i or negedge reset_i) begin
    if (!reset_i) begin
      enableQ <= 1'b0;
      commonQ <= '0;
      flagsQ  <= '0;
      crQ     <= 1'b0;
      bodyQ   <= '0;
    end else begin
      enableQ <= enableD;
      commonQ <= commonD;
      flagsQ  <= flagsD;
      crQ     <= crD;
      bodyQ   <= bodyD;
    end
  end

  assign enable_o       = enableQ;
  assign opcode_o       = commonQ.opcode;
  assign address_o      = commonQ.address;
  assign funcUnitType_o = commonQ.unitType;
  assign majID_o        = commonQ.majId;
  assign minID_o        = commonQ.minId;
  assign numMicroOps_o  = commonQ.numMicroOps;
  assign is64Bit_o      = commonQ.is64Bit;
  assign pid_o          = commonQ.pid;
  assign tid_o          = commonQ.tid;
  assign op1rw_o        = flagsQ.op1rw;
  assign op2rw_o        = flagsQ.op2rw;
  assign op3rw_o        = flagsQ.op3rw;
  assign op4rw_o        = flagsQ.op4rw;
  assign op1IsReg_o     = flagsQ.op1IsReg;
  assign op2IsReg_o     = flagsQ.op2IsReg;
  assign op3IsReg_o     = flagsQ.op3IsReg;
  assign op4IsReg_o     = flagsQ.op4IsReg;
  assign modifiesCR_o   = crQ;
  assign body_o         = bodyQ;

endmodule

// File: tb/tb_decode_mux.sv
// Self-checking bench for decode_mux: directed steps followed by random traffic checked against
// an arithmetic reference model (format index 0 = A, 1 = B, 2 = D).
module tb_decode_mux;

  logic clk, rstN;

  logic        en     [3];
  logic [11:0] opc    [3];
  logic [63:0] addr   [3];
  logic [2:0]  unit   [3];
  logic [63:0] maj    [3];
  logic [4:0]  minId  [3];
  logic [4:0]  nUops  [3];
  logic        is64   [3];
  logic [19:0] pid    [3];
  logic [15:0] tid    [3];
  logic [1:0]  aRw    [4];
  logic        aIsReg [4];
  logic [20:0] aBody;
  logic [27:0] bBody;
  logic [1:0]  dRw    [2];
  logic        dIsReg [2];
  logic        immExt, immSh;
  logic [2:0]  shBy;
  logic [25:0] dBody;

  logic        oEn, oIs64, oCr;
  logic [11:0] oOpc;
  logic [63:0] oAddr, oMaj, oBody;
  logic [2:0]  oUnit;
  logic [4:0]  oMin, oNum;
  logic [19:0] oPid;
  logic [15:0] oTid;
  logic [1:0]  oRw1, oRw2, oRw3, oRw4;
  logic        oIsReg1, oIsReg2, oIsReg3, oIsReg4;

  // Reference state
  logic        expEn, expIs64, expCr;
  logic [11:0] expOpc;
  logic [63:0] expAddr, expMaj, expBody;
  logic [2:0]  expUnit;
  logic [4:0]  expMin, expNum;
  logic [19:0] expPid;
  logic [15:0] expTid;
  logic [7:0]  expRw;
  logic [3:0]  expIsReg;

  int checks = 0;
  int errors = 0;

  decode_mux dut (
    .clock_i(clk), .reset_i(rstN),
    .Aenable_i(en[0]), .AOpcode_i(opc[0]), .AAddress_i(addr[0]), .AUnitType_i(unit[0]),
    .AMajId_i(maj[0]), .AMinId_i(minId[0]), .AnumMicroOps_i(nUops[0]), .Ais64Bit_i(is64[0]),
    .APid_i(pid[0]), .ATid_i(tid[0]),
    .Aop1rw_i(aRw[0]), .Aop2rw_i(aRw[1]), .Aop3rw_i(aRw[2]), .Aop4rw_i(aRw[3]),
    .Aop1IsReg_i(aIsReg[0]), .Aop2IsReg_i(aIsReg[1]), .Aop3IsReg_i(aIsReg[2]),
    .Aop4IsReg_i(aIsReg[3]), .ABody_i(aBody),
    .Benable_i(en[1]), .BOpcode_i(opc[1]), .BAddress_i(addr[1]), .BUnitType_i(unit[1]),
    .BMajId_i(maj[1]), .BMinId_i(minId[1]), .BnumMicroOps_i(nUops[1]), .Bis64Bit_i(is64[1]),
    .BPid_i(pid[1]), .BTid_i(tid[1]), .BBody_i(bBody),
    .Denable_i(en[2]), .DOpcode_i(opc[2]), .DAddress_i(addr[2]), .DUnitType_i(unit[2]),
    .DMajId_i(maj[2]), .DMinId_i(minId[2]), .DnumMicroOps_i(nUops[2]), .Dis64Bit_i(is64[2]),
    .DPid_i(pid[2]), .DTid_i(tid[2]),
    .Dop1rw_i(dRw[0]), .Dop2rw_i(dRw[1]), .Dop1isReg_i(dIsReg[0]), .Dop2isReg_i(dIsReg[1]),
    .immIsExtended_i(immExt), .immIsShifted_i(immSh), .DisShiftedBy_i(shBy), .DBody_i(dBody),
    .enable_o(oEn), .opcode_o(oOpc), .address_o(oAddr), .funcUnitType_o(oUnit),
    .majID_o(oMaj), .minID_o(oMin), .numMicroOps_o(oNum), .is64Bit_o(oIs64),
    .pid_o(oPid), .tid_o(oTid),
    .op1rw_o(oRw1), .op2rw_o(oRw2), .op3rw_o(oRw3), .op4rw_o(oRw4),
    .op1IsReg_o(oIsReg1), .op2IsReg_o(oIsReg2), .op3IsReg_o(oIsReg3), .op4IsReg_o(oIsReg4),
    .modifiesCR_o(oCr), .body_o(oBody)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic checkAll(input string ctx);
    check({ctx, ".enable"}, 64'(oEn), 64'(expEn));
    check({ctx, ".opcode"}, 64'(oOpc), 64'(expOpc));
    check({ctx, ".address"}, oAddr, expAddr);
    check({ctx, ".unit"}, 64'(oUnit), 64'(expUnit));
    check({ctx, ".majId"}, oMaj, expMaj);
    check({ctx, ".minId"}, 64'(oMin), 64'(expMin));
    check({ctx, ".numUops"}, 64'(oNum), 64'(expNum));
    check({ctx, ".is64"}, 64'(oIs64), 64'(expIs64));
    check({ctx, ".pid"}, 64'(oPid), 64'(expPid));
    check({ctx, ".tid"}, 64'(oTid), 64'(expTid));
    check({ctx, ".rw"}, 64'({oRw1, oRw2, oRw3, oRw4}), 64'(expRw));
    check({ctx, ".isReg"}, 64'({oIsReg1, oIsReg2, oIsReg3, oIsReg4}), 64'(expIsReg));
    check({ctx, ".modifiesCR"}, 64'(oCr), 64'(expCr));
    check({ctx, ".body"}, oBody, expBody);
  endtask

  // D body as a number: RT*2^59 + RA*2^54 + (imm extended, then times 256^by, modulo 2^54)
  function automatic logic [63:0] dBodyModel(input logic [25:0] b, input logic ext,
                                             input logic sh, input logic [2:0] by);
    logic [63:0] v;
    v = 64'(b[15:0]);
    if (ext && b[15]) v = v | 64'h003F_FFFF_FFFF_0000;
    if (sh) v = (v << (8 * int'(by))) & 64'h003F_FFFF_FFFF_FFFF;
    return (64'(b[25:21]) << 59) | (64'(b[20:16]) << 54) | v;
  endfunction

  task automatic modelReset();
    expEn = 0; expIs64 = 0; expCr = 0; expOpc = 0; expAddr = 0; expMaj = 0; expBody = 0;
    expUnit = 0; expMin = 0; expNum = 0; expPid = 0; expTid = 0; expRw = 0; expIsReg = 0;
  endtask

  task automatic modelStep();
    int sel;
    sel = en[0] ? 0 : en[1] ? 1 : en[2] ? 2 : -1;
    expEn = (sel >= 0);
    if (sel >= 0) begin
      expOpc = opc[sel]; expAddr = addr[sel]; expUnit = unit[sel]; expMaj = maj[sel];
      expMin = minId[sel]; expNum = nUops[sel]; expIs64 = is64[sel];
      expPid = pid[sel]; expTid = tid[sel];
    end
    if (sel == 0) begin
      expRw    = {aRw[0], aRw[1], aRw[2], aRw[3]};
      expIsReg = {aIsReg[0], aIsReg[1], aIsReg[2], aIsReg[3]};
      expBody  = 64'(aBody) << 43;
      expCr    = aBody[0];
    end else if (sel == 1) begin
      expRw = 0; expIsReg = 0; expCr = 0;
      expBody = 64'(bBody) << 36;
    end else if (sel == 2) begin
      expRw    = {dRw[0], dRw[1], 4'b0000};
      expIsReg = {dIsReg[0], dIsReg[1], 2'b00};
      expCr    = 0;
      expBody  = dBodyModel(dBody, immExt, immSh, shBy);
    end
  endtask

  task automatic cycle(input string ctx);
    modelStep();
    @(posedge clk);
    @(negedge clk);
    checkAll(ctx);
  endtask

  task automatic clearInputs();
    for (int i = 0; i < 3; i++) begin
      en[i] = 0; opc[i] = 0; addr[i] = 0; unit[i] = 0; maj[i] = 0; minId[i] = 0;
      nUops[i] = 0; is64[i] = 0; pid[i] = 0; tid[i] = 0;
    end
    for (int i = 0; i < 4; i++) begin aRw[i] = 0; aIsReg[i] = 0; end
    for (int i = 0; i < 2; i++) begin dRw[i] = 0; dIsReg[i] = 0; end
    aBody = 0; bBody = 0; dBody = 0; immExt = 0; immSh = 0; shBy = 0;
  endtask

  task automatic randomizeInputs();
    for (int i = 0; i < 3; i++) begin
      en[i] = ($urandom_range(0, 2) == 0);
      opc[i] = 12'($urandom); addr[i] = {$urandom, $urandom}; unit[i] = 3'($urandom);
      maj[i] = {$urandom, $urandom}; minId[i] = 5'($urandom); nUops[i] = 5'($urandom);
      is64[i] = 1'($urandom); pid[i] = 20'($urandom); tid[i] = 16'($urandom);
    end
    for (int i = 0; i < 4; i++) begin aRw[i] = 2'($urandom); aIsReg[i] = 1'($urandom); end
    for (int i = 0; i < 2; i++) begin dRw[i] = 2'($urandom); dIsReg[i] = 1'($urandom); end
    aBody = 21'($urandom); bBody = 28'($urandom); dBody = 26'($urandom);
    immExt = 1'($urandom); immSh = 1'($urandom); shBy = 3'($urandom);
  endtask

  initial begin
    rstN = 1'b0;
    clearInputs();
    modelReset();

    // Reset state, then release with nothing valid
    #12;
    checkAll("reset");
    rstN = 1'b1;
    cycle("idle");

    // Directed A uop
    en[0] = 1; opc[0] = 12'd4; unit[0] = 3'd1; is64[0] = 1;
    aRw[0] = 2'b01; aRw[1] = 2'b10; aRw[2] = 2'b00; aRw[3] = 2'b10;
    aIsReg[0] = 1; aIsReg[1] = 1; aIsReg[2] = 0; aIsReg[3] = 1;
    aBody = 21'b10001_01110_11111_00000_1;
    cycle("dirA");
    check("dirA.bodyConst", oBody, {21'b10001_01110_11111_00000_1, 43'b0});
    check("dirA.crConst", 64'(oCr), 64'd1);
    check("dirA.rwConst", 64'({oRw1, oRw2, oRw3, oRw4}), 64'(8'b01_10_00_10));
    en[0] = 0;
    cycle("dirA.hold");
    check("hold.enableConst", 64'(oEn), 64'd0);
    check("hold.opcodeConst", 64'(oOpc), 64'd4);

    // Directed D uops: sign extension, then zero-extended byte shift
    en[2] = 1; dRw[0] = 2'b01; dRw[1] = 2'b10; dIsReg[0] = 1; dIsReg[1] = 1;
    dBody = {5'd3, 5'd1, 16'hFFFE}; immExt = 1; immSh = 0;
    cycle("dirD.ext");
    check("dirD.extConst", oBody, {5'd3, 5'd1, 54'h3F_FFFF_FFFF_FFFE});
    check("dirD.rw34Const", 64'({oRw3, oRw4}), 64'd0);
    dBody = {5'd3, 5'd1, 16'h0001}; immSh = 1; shBy = 3'd2;
    cycle("dirD.shift");
    check("dirD.shiftConst", oBody, {5'd3, 5'd1, 54'h10000});

    // Priority: A beats D, then B beats D
    en[0] = 1; en[2] = 1; opc[0] = 12'd7; opc[2] = 12'd9;
    cycle("prioAD");
    check("prioAD.opcodeConst", 64'(oOpc), 64'd7);
    en[0] = 0; en[1] = 1; opc[1] = 12'd11; bBody = 28'hABCDEF1;
    cycle("prioBD");
    check("prioBD.opcodeConst", 64'(oOpc), 64'd11);
    check("prioBD.crConst", 64'(oCr), 64'd0);

    // Random traffic
    for (int n = 0; n < 300; n++) begin
      randomizeInputs();
      cycle("rand");
    end

    // Asynchronous reset between edges while a uop is being presented
    randomizeInputs();
    en[0] = 1;
    cycle("preRst");
    check("preRst.enableConst", 64'(oEn), 64'd1);
    #2;
    rstN = 1'b0;
    #1;
    modelReset();
    checkAll("asyncRst");
    @(negedge clk);
    randomizeInputs();
    en[0] = 0; en[1] = 0; en[2] = 1;
    rstN = 1'b1;
    cycle("afterRst");
    check("afterRst.enableConst", 64'(oEn), 64'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
